// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Multi-digit hex seven-segment driver. A snapshot register (shadow) captures
// `value` on `load`; all decoding works from the snapshot. Two output views:
//   - a time-multiplexed scan (seg_n / dig_sel_n) with one guard cycle at the
//     start of every digit slot to stop ghosting between digits;
//   - a static per-digit decode bus (hex_n) for directly wired displays.
// Leading-zero blanking, per-digit enables and (optionally) blinking decide
// whether a digit is visible. Every output is registered.
//
// Optional feature macro: SEG_BLINK_EN
//   Adds the blink_mask port, a frame counter and a blink phase register.
//
// Parameters:
//   NUM_DIGITS  number of hex digits (1..8)
//   SCAN_DIV    clock cycles per digit slot (>= 2)
//   BLINK_DIV   complete scan frames per blink phase (used with SEG_BLINK_EN)
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   value       hex digits, digit i at [4i+3:4i]
//   load        snapshot strobe for value
//   digit_en    per-digit enable (0 blanks the digit)
//   lz_blank    1 suppresses leading zeros (digit 0 is never suppressed)
//   blink_mask  digits that blink (SEG_BLINK_EN only)
//   seg_n       scanned segments, active-low, bit0=a .. bit6=g
//   dig_sel_n   scanned digit select, one-hot active-low
//   hex_n       static decode, digit i at [7i+6:7i], active-low
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_blank,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     dig_sel_n,
    output logic [7*NUM_DIGITS-1:0]   hex_n
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       BLANK    = 7'h7F;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0]       shadow_reg;
    logic [CNT_W-1:0]              cnt_reg;
    logic [IDX_W-1:0]              idx_reg;
    logic [6:0]                    seg_reg;
    logic [NUM_DIGITS-1:0]         dig_sel_reg;
    logic [7*NUM_DIGITS-1:0]       hex_reg;

    logic                          cnt_wrap;
    logic                          frame_end;
    logic [NUM_DIGITS-1:0]         blink_hide;
    logic [NUM_DIGITS-1:0]         lz_keep;
    logic [NUM_DIGITS-1:0]         visible;
    logic [NUM_DIGITS-1:0][6:0]    hex_next;
    logic [6:0]                    seg_next;
    logic [NUM_DIGITS-1:0]         dig_sel_next;

    assign cnt_wrap  = (cnt_reg == CNT_LAST);
    assign frame_end = cnt_wrap && (idx_reg == IDX_LAST);

`ifdef SEG_BLINK_EN
    localparam int FR_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_DIV - 1);

    logic [FR_W-1:0] frame_reg;
    logic            phase_reg;

    // Phase flips once every BLINK_DIV completed frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_reg <= '0;
            phase_reg <= 1'b0;
        end else if (frame_end) begin
            if (frame_reg == FR_LAST) begin
                frame_reg <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                frame_reg <= frame_reg + FR_W'(1);
            end
        end
    end

    assign blink_hide = phase_reg ? blink_mask : '0;
`else
    assign blink_hide = '0;
`endif

    // Per-digit visibility and static decode.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                // The least significant digit always survives blanking so
                // that a zero value still shows a single "0".
                assign lz_keep[gi] = 1'b1;
            end else begin : g_upper
                // Keep the digit if anything at or above it is non-zero.
                assign lz_keep[gi] = !lz_blank || (|shadow_reg[4*NUM_DIGITS-1:4*gi]);
            end
            assign visible[gi]  = digit_en[gi] && lz_keep[gi] && !blink_hide[gi];
            assign hex_next[gi] = visible[gi] ? glyph(shadow_reg[4*gi +: 4]) : BLANK;
        end
    endgenerate

    // Scan output: cnt==0 is the guard cycle with every digit released.
    always_comb begin
        seg_next     = BLANK;
        dig_sel_next = '1;
        if (cnt_reg != '0) begin
            seg_next     = hex_next[idx_reg];
            dig_sel_next = ~(NUM_DIGITS'(1) << idx_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_reg  <= '0;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            seg_reg     <= BLANK;
            dig_sel_reg <= '1;
            hex_reg     <= '1;
        end else begin
            if (load) begin
                shadow_reg <= value;
            end
            cnt_reg <= cnt_wrap ? '0 : cnt_reg + CNT_W'(1);
            if (cnt_wrap) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            end
            seg_reg     <= seg_next;
            dig_sel_reg <= dig_sel_next;
            hex_reg     <= hex_next;
        end
    end

    assign seg_n     = seg_reg;
    assign dig_sel_n = dig_sel_reg;
    assign hex_n     = hex_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Self-checking bench for seven_seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2. A behavioural model predicts the registered outputs for each
// clock edge; the prediction is queued before the edge and compared after it.
// Scenario tasks add fixed expectations taken from the display glyph table.
// Blink scenarios are built only when SEG_BLINK_EN is defined.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   value;
    logic          load;
    logic [3:0]    digit_en;
    logic          lz_blank;
    logic [3:0]    blink_mask;
    logic [6:0]    seg_n;
    logic [3:0]    dig_sel_n;
    logic [27:0]   hex_n;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [15:0]   m_shadow;
    int            m_cnt;
    int            m_idx;
    int            m_frame;
    logic          m_phase;

    logic [38:0]   exp_q[$];

    seven_seg_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
`ifdef SEG_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg_n      (seg_n),
        .dig_sel_n  (dig_sel_n),
        .hex_n      (hex_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected {seg_n, dig_sel_n, hex_n} after the coming edge.
    function automatic logic [38:0] model_out();
        logic [27:0] hx;
        logic [6:0]  s;
        logic [3:0]  d;
        logic        vis;
        if (reset) return {7'h7F, 4'hF, {28{1'b1}}};
        for (int i = 0; i < ND; i++) begin
            vis = digit_en[i];
            if (lz_blank && i > 0 && ((m_shadow >> (4 * i)) == 16'h0)) vis = 1'b0;
`ifdef SEG_BLINK_EN
            if (m_phase && blink_mask[i]) vis = 1'b0;
`endif
            hx[7*i +: 7] = vis ? ref_glyph(m_shadow[4*i +: 4]) : 7'h7F;
        end
        if (m_cnt == 0) begin
            s = 7'h7F;
            d = 4'hF;
        end else begin
            s = hx[7*m_idx +: 7];
            d = ~(4'b0001 << m_idx);
        end
        return {s, d, hx};
    endfunction

    // Queue the prediction, clock once, advance the model, settle.
    task automatic tick();
        exp_q.push_back(model_out());
        @(posedge clk);
        if (reset) begin
            m_shadow = 16'h0;
            m_cnt    = 0;
            m_idx    = 0;
            m_frame  = 0;
            m_phase  = 1'b0;
        end else begin
            if (load) m_shadow = value;
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                if (m_idx == ND - 1) begin
                    m_idx = 0;
                    if (m_frame == BD - 1) begin
                        m_frame = 0;
                        m_phase = ~m_phase;
                    end else begin
                        m_frame++;
                    end
                end else begin
                    m_idx++;
                end
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [38:0] e;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({seg_n, dig_sel_n, hex_n} !== {7'h7F, 4'hF, {28{1'b1}}}) begin
                errors++;
                $display("FAIL reset_hold: got %h required %h", {seg_n, dig_sel_n, hex_n}, e);
            end
        end
        reset = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (seg_n !== 7'h7F || dig_sel_n !== 4'hF) begin
            errors++;
            $display("FAIL first_guard: got seg=%h sel=%b required seg=7f sel=1111", seg_n, dig_sel_n);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (seg_n !== 7'h40 || dig_sel_n !== 4'b1110) begin
                errors++;
                $display("FAIL first_drive%0d: got seg=%h sel=%b required seg=40 sel=1110", i, seg_n, dig_sel_n);
            end
        end
        $display("test_reset done");
    endtask

    // Run n cycles comparing every edge against the model.
    task automatic test_scan(input string name, input int n);
        logic [38:0] e;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({seg_n, dig_sel_n, hex_n} !== e) begin
                errors++;
                $display("FAIL %s cyc%0d: got %h required %h", name, i, {seg_n, dig_sel_n, hex_n}, e);
            end
        end
        $display("%s: %0d cycles compared", name, n);
    endtask

    task automatic test_load(input logic [15:0] v, input logic lz, input logic [27:0] want_hex);
        logic [38:0] e;
        value    = v;
        lz_blank = lz;
        load     = 1'b1;
        tick();
        e = exp_q.pop_front();
        load = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hex_n !== want_hex || {seg_n, dig_sel_n, hex_n} !== e) begin
            errors++;
            $display("FAIL load_%h: got hex=%h required %h", v, hex_n, want_hex);
        end
        $display("load %h lz=%b hex_n=%h", v, lz, hex_n);
    endtask

    task automatic test_midload();
        logic [38:0] e;
        int n = 0;
        lz_blank = 1'b0;
        value = 16'h0000;
        load  = 1'b1;
        tick();
        e = exp_q.pop_front();
        load = 1'b0;
        while (!(m_cnt == 2 && m_idx == 1) && n < 64) begin
            tick();
            e = exp_q.pop_front();
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL midload_wait: got timeout required digit1 drive slot");
        end
        value = 16'h0090;
        load  = 1'b1;
        tick();
        e = exp_q.pop_front();
        load = 1'b0;
        checks++;
        if (seg_n !== 7'h40 || dig_sel_n !== 4'b1101) begin
            errors++;
            $display("FAIL midload_before: got seg=%h sel=%b required seg=40 sel=1101", seg_n, dig_sel_n);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (seg_n !== 7'h10 || dig_sel_n !== 4'b1101) begin
            errors++;
            $display("FAIL midload_after: got seg=%h sel=%b required seg=10 sel=1101", seg_n, dig_sel_n);
        end
        $display("test_midload seg_n=%h dig_sel_n=%b", seg_n, dig_sel_n);
    endtask

    task automatic test_back_to_back();
        logic [38:0] e;
        load = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            value = 16'h1111 * i[15:0];
            tick();
            e = exp_q.pop_front();
        end
        load = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hex_n !== {7'h30, 7'h30, 7'h30, 7'h30} || {seg_n, dig_sel_n, hex_n} !== e) begin
            errors++;
            $display("FAIL back_to_back: got hex=%h required %h", hex_n, {7'h30, 7'h30, 7'h30, 7'h30});
        end
        $display("test_back_to_back hex_n=%h", hex_n);
    endtask

    task automatic test_reset_midframe();
        logic [38:0] e;
        test_scan("pre_reset", 6);
        reset = 1'b1;
        tick();
        e = exp_q.pop_front();
        reset = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (seg_n !== 7'h7F || dig_sel_n !== 4'hF) begin
            errors++;
            $display("FAIL midframe_guard: got seg=%h sel=%b required guard", seg_n, dig_sel_n);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (dig_sel_n !== 4'b1110 || seg_n !== 7'h40) begin
            errors++;
            $display("FAIL midframe_restart: got seg=%h sel=%b required seg=40 sel=1110", seg_n, dig_sel_n);
        end
        $display("test_reset_midframe done");
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        logic [38:0] e;
        int n = 0;
        blink_mask = 4'b0001;
        lz_blank   = 1'b0;
        reset = 1'b1;
        tick();
        e = exp_q.pop_front();
        reset = 1'b0;
        value = 16'h1234;
        load  = 1'b1;
        tick();
        e = exp_q.pop_front();
        load = 1'b0;
        test_scan("blink", 140);
        while (!m_phase && n < 64) begin
            tick();
            e = exp_q.pop_front();
            n++;
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hex_n[6:0] !== 7'h7F) begin
            errors++;
            $display("FAIL blink_hidden: got %h required 7f", hex_n[6:0]);
        end
        reset = 1'b1;
        tick();
        e = exp_q.pop_front();
        reset = 1'b0;
        load  = 1'b1;
        tick();
        e = exp_q.pop_front();
        load = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hex_n[6:0] !== 7'h19) begin
            errors++;
            $display("FAIL blink_reset_phase: got %h required 19", hex_n[6:0]);
        end
        blink_mask = 4'b0000;
        $display("test_blink done");
    endtask
`endif

    initial begin
        reset      = 1'b1;
        value      = 16'h0;
        load       = 1'b0;
        digit_en   = 4'hF;
        lz_blank   = 1'b0;
        blink_mask = 4'h0;
        m_shadow   = 16'h0;
        m_cnt      = 0;
        m_idx      = 0;
        m_frame    = 0;
        m_phase    = 1'b0;

        test_reset();
        test_load(16'h1A2F, 1'b0, {7'h79, 7'h08, 7'h24, 7'h0E});
        test_scan("scan_1a2f", 40);
        test_load(16'h0050, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40});
        test_scan("lz_0050", 20);
        test_load(16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        test_scan("lz_0000", 20);
        test_midload();
        digit_en = 4'b0101;
        test_load(16'hC3D7, 1'b0, {7'h7F, 7'h30, 7'h7F, 7'h78});
        test_scan("digit_en", 20);
        digit_en = 4'hF;
        test_back_to_back();
        test_reset_midframe();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised multi-digit seven-segment display driver with a registered value snapshot, time-multiplexed scanning and leading-zero blanking. It also provides a registered static per-digit decode bus for boards that wire every digit directly. It sits between datapath registers and the board's HEX/segment pins. It replaces per-digit combinational hex decoders instantiated by hand.

## Interface
Parameters:
- NUM_DIGITS, 6, number of hex digits (1..8)
- SCAN_DIV, 50000, clock cycles per digit slot (>= 2)
- BLINK_DIV, 25, complete scan frames per blink phase (only with SEG_BLINK_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 least significant
- load  in  1  capture strobe; value is snapshotted on the clock edge where load=1
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
- lz_blank  in  1  1 = suppress leading zeros
- blink_mask  in  NUM_DIGITS  digits to blink (only with SEG_BLINK_EN)
- seg_n  out  7  scanned segments, active-low, bit0=a … bit6=g
- dig_sel_n  out  NUM_DIGITS  scanned digit select, one-hot active-low
- hex_n  out  7*NUM_DIGITS  static decode, digit i at [7i+6:7i], active-low

## Operation
- Glyphs (seg_n[6:0], hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; blank=7F.
- Snapshot register `shadow` loads value when load=1 and holds otherwise. All decoding uses shadow, never value directly.
- Digit i is visible when all of the following hold:
  - digit_en[i]=1;
  - not (lz_blank=1 and i>0 and shadow digits i..NUM_DIGITS-1 are all zero);
  - not blink-blanked.
- Digit 0 is never blanked by lz_blank, so zero displays as a single "0".
- Scan FSM uses a slot counter `cnt` (0..SCAN_DIV-1) and a digit index `idx` (0..NUM_DIGITS-1).
  - `cnt` increments every cycle and wraps to 0 after SCAN_DIV-1.
  - On wrap, `idx` increments; it wraps from NUM_DIGITS-1 to 0, which ends one scan frame.
  - cnt==0 is the guard phase: dig_sel_n is all ones and seg_n=7F (anti-ghosting).
  - cnt!=0 is the drive phase: dig_sel_n[idx]=0, others 1; seg_n = glyph of shadow digit idx, or 7F if that digit is not visible.
- A visibility-blanked digit still occupies its slot, and its select line is still asserted during the drive phase.
- hex_n[i] = glyph of shadow digit i if visible, else 7F, for all digits in parallel.
- Reset forces:
  - shadow=0, cnt=0, idx=0;
  - seg_n=7F, dig_sel_n all ones, hex_n all ones;
  - blink phase=0.
- Reset mid-frame aborts the current slot; scanning restarts at the digit 0 guard cycle.

## Timing
- All outputs are registered. Outputs at edge t+1 reflect shadow, cnt, idx and control inputs as they are after edge t.
- load → visible: shadow updates at edge t. hex_n and seg_n (if the driven digit changed) update at edge t+1, mid-slot, with no wait for a slot boundary.
- digit_en and lz_blank are sampled every cycle and take effect with 1-cycle latency.
- Slot period is SCAN_DIV cycles: 1 guard cycle plus SCAN_DIV-1 drive cycles.
- Frame period is NUM_DIGITS*SCAN_DIV cycles.
- After reset release, the first guard cycle is output at the first edge, and digit 0 is driven from the 2nd edge.
- load asserted on consecutive cycles loads every cycle, last value wins.
- NUM_DIGITS=1: idx stays 0; the guard cycle still occurs every slot.

## Configuration
- SEG_BLINK_EN defined:
  - adds the blink_mask port and a frame counter (0..BLINK_DIV-1);
  - the blink phase toggles at each frame end where the frame counter wraps;
  - while phase=1, digits with blink_mask[i]=1 are not visible on both seg_n and hex_n.
- SEG_BLINK_EN undefined: no blink_mask port, no frame counter, no phase register; visibility ignores blinking.

## Test plan
NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
- Reset held 3 cycles, then released:
  - seg_n=7F, dig_sel_n=1111, hex_n all ones during reset;
  - first edge after release: guard cycle;
  - next 3 cycles: dig_sel_n=1110, seg_n=40.
- load with value=16'h1A2F, digit_en=1111, lz_blank=0:
  - hex_n digits 0..3 = 0E,24,08,79;
  - scan sequence per slot: guard, then 3 drive cycles of F, 2, A, 1 on dig_sel_n 1110, 1101, 1011, 0111;
  - frame repeats every 16 cycles.
- value=16'h0050, lz_blank=1:
  - digits 3 and 2 blank (7F) with their select lines still asserted; digits 1 and 0 show 12 and 40;
  - value=0000: only digit 0 shows 40.
- load pulse mid-drive of digit 1, value 16'h0000→16'h0090: seg_n changes 40→10 on the next edge; dig_sel_n is unchanged.
- SEG_BLINK_EN, blink_mask=0001, value=16'h1234:
  - digit 0 shows 19 for 2 frames (32 cycles), then 7F for 2 frames, repeating;
  - reset mid-blink returns phase to visible.
